phys_reg_file_sb: RTL

Parametrised, scoreboarded physical register file for the out-of-order core.
- Holds renamed register values plus a per-register ready bit, so rename/issue can check operand availability.
- Supports N read ports with optional same-cycle writeback bypass, M writeback ports, and K allocation ports that clear ready bits.
- Low-numbered registers are hardwired constants.
- Sits between the rename stage (alloc ports), the issue/dispatch stage (read ports) and the execution-unit writeback buses (write ports).

---
 rtl/prf_pkg.sv | 12 +
 rtl/prf_read_port.sv | 44 ++++
 rtl/phys_reg_file_sb.sv | 106 ++++++++++
 3 files changed

// File: rtl/prf_pkg.sv
// Shared physical-register-file sizing for rename, issue and the register file itself.
package prf_pkg;

    localparam int PRF_DATA_W    = 8;
    localparam int PRF_NUM_REGS  = 32;
    localparam int PRF_NUM_CONST = 2;
    localparam int PRF_AW        = $clog2(PRF_NUM_REGS);

    // Register i reads slice i: reg0 = 8'h00, reg1 = 8'h01.
    localparam logic [PRF_NUM_CONST*PRF_DATA_W-1:0] PRF_CONST_VALS = {8'h01, 8'h00};

endpackage

// File: rtl/prf_read_port.sv
// One combinational read port: constant decode, storage lookup, highest-index writeback bypass.
// Zero latency; no flow control.
module prf_read_port
    import prf_pkg::*;
#(
    parameter int                              DATA_W     = PRF_DATA_W,
    parameter int                              NUM_REGS   = PRF_NUM_REGS,
    parameter int                              NUM_CONST  = PRF_NUM_CONST,
    parameter logic [NUM_CONST*DATA_W-1:0]     CONST_VALS = PRF_CONST_VALS,
    parameter int                              NUM_WR     = 6,
    parameter int                              BYPASS     = 1,
    parameter int                              AW         = $clog2(NUM_REGS)
) (
    input  logic [AW-1:0]                      i_addr,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]    i_regs,
    input  logic [NUM_REGS-1:0]                i_ready,
    input  logic [NUM_WR-1:0]                  i_wr_en,
    input  logic [NUM_WR*AW-1:0]               i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]           i_wr_data,
    output logic [DATA_W-1:0]                  o_data,
    output logic                               o_ready
);

    always_comb begin
        o_data  = '0;
        o_ready = 1'b1;
        if (int'(i_addr) < NUM_CONST) begin
            o_data = CONST_VALS[int'(i_addr)*DATA_W +: DATA_W];
        end else if (int'(i_addr) < NUM_REGS) begin
            o_data  = i_regs[i_addr];
            o_ready = i_ready[i_addr];
            // Ascending scan so the highest-index matching write port is the one left standing.
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == i_addr)) begin
                        o_data  = i_wr_data[j*DATA_W +: DATA_W];
                        o_ready = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/phys_reg_file_sb.sv
// Scoreboarded physical register file: storage, ready bits, busy popcount; reads are combinational.
// Writes/allocs/flush take effect on the next rising edge, busy_count one edge after the event; no backpressure.
module phys_reg_file_sb
    import prf_pkg::*;
#(
    parameter int                              DATA_W     = PRF_DATA_W,
    parameter int                              NUM_REGS   = PRF_NUM_REGS,
    parameter int                              NUM_CONST  = PRF_NUM_CONST,
    parameter logic [NUM_CONST*DATA_W-1:0]     CONST_VALS = PRF_CONST_VALS,
    parameter int                              NUM_RD     = 12,
    parameter int                              NUM_WR     = 6,
    parameter int                              NUM_ALLOC  = 2,
    parameter int                              BYPASS     = 1,
    parameter int                              AW         = $clog2(NUM_REGS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_RD*AW-1:0]               rd_addr,
    output logic [NUM_RD*DATA_W-1:0]           rd_data,
    output logic [NUM_RD-1:0]                  rd_ready,
    input  logic [NUM_WR-1:0]                  wr_en,
    input  logic [NUM_WR*AW-1:0]               wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]           wr_data,
    input  logic [NUM_ALLOC-1:0]               alloc_en,
    input  logic [NUM_ALLOC*AW-1:0]            alloc_addr,
    input  logic                               flush,
    output logic [AW:0]                        busy_count
);

    logic [NUM_REGS-1:0][DATA_W-1:0] r_data;
    logic [NUM_REGS-1:0]             r_ready;
    logic [AW:0]                     r_busy_count;

    logic [NUM_REGS-1:0][DATA_W-1:0] w_data_nxt;
    logic [NUM_REGS-1:0]             w_ready_nxt;
    logic [AW:0]                     w_busy_nxt;

    function automatic logic f_writable(input logic [AW-1:0] a);
        return (int'(a) >= NUM_CONST) && (int'(a) < NUM_REGS);
    endfunction

    // Later assignments override earlier ones: write, then alloc, then flush.
    always_comb begin
        w_data_nxt  = r_data;
        w_ready_nxt = r_ready;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && f_writable(wr_addr[j*AW +: AW])) begin
                w_data_nxt[wr_addr[j*AW +: AW]]  = wr_data[j*DATA_W +: DATA_W];
                w_ready_nxt[wr_addr[j*AW +: AW]] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_ALLOC; i++) begin
            if (alloc_en[i] && f_writable(alloc_addr[i*AW +: AW])) begin
                w_ready_nxt[alloc_addr[i*AW +: AW]] = 1'b0;
            end
        end
        if (flush) begin
            w_ready_nxt = '1;
        end
    end

    always_comb begin
        w_busy_nxt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!w_ready_nxt[r]) begin
                w_busy_nxt = w_busy_nxt + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data       <= '0;
            r_ready      <= '1;
            r_busy_count <= '0;
        end else begin
            r_data       <= w_data_nxt;
            r_ready      <= w_ready_nxt;
            r_busy_count <= w_busy_nxt;
        end
    end

    assign busy_count = r_busy_count;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        prf_read_port #(
            .DATA_W     (DATA_W),
            .NUM_REGS   (NUM_REGS),
            .NUM_CONST  (NUM_CONST),
            .CONST_VALS (CONST_VALS),
            .NUM_WR     (NUM_WR),
            .BYPASS     (BYPASS),
            .AW         (AW)
        ) u_rd (
            .i_addr    (rd_addr[k*AW +: AW]),
            .i_regs    (r_data),
            .i_ready   (r_ready),
            .i_wr_en   (wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .o_data    (rd_data[k*DATA_W +: DATA_W]),
            .o_ready   (rd_ready[k])
        );
    end

endmodule
